// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between two producers, the arbiter and the FIFO input side.
// The arbiter takes the slave view; the master view drives producers and FIFO flag.
interface fifo_wr_arbiter_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic          req0;
  logic [DW-1:0] din0;
  logic          req1;
  logic [DW-1:0] din1;
  logic          gnt0;
  logic          gnt1;
  logic          ack0;
  logic          ack1;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data_in;
  logic [CW-1:0] burst_cnt;

  modport slave (
    input  req0, din0, req1, din1, fifo_full,
    output gnt0, gnt1, ack0, ack1, fifo_wr_en, fifo_data_in, burst_cnt
  );

  modport master (
    output req0, din0, req1, din1, fifo_full,
    input  gnt0, gnt1, ack0, ack1, fifo_wr_en, fifo_data_in, burst_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of a single FIFO write port shared by two producers.
// Grants last up to MAX_BURST beats; a full FIFO stalls the owner without ending its burst.
module fifo_wr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int CW        = 8
) (
  input  logic               clk,
  input  logic               rst,
  fifo_wr_arbiter_if.slave   bus
);

  if (MAX_BURST < 1 || MAX_BURST > 255 || (2 ** CW) <= MAX_BURST) begin : g_bad_params
    $error("fifo_wr_arbiter: MAX_BURST must be 1..255 and fit in CW bits");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] burst_q, burst_d;
  logic          last_q, last_d;

  logic own0, own1;
  logic beat0, beat1;
  logic at_limit;
  logic rel0, rel1;

  assign own0     = (state_q == OWN0);
  assign own1     = (state_q == OWN1);
  assign beat0    = own0 && bus.req0 && !bus.fifo_full;
  assign beat1    = own1 && bus.req1 && !bus.fifo_full;
  assign at_limit = (burst_q == LAST_BEAT);

  // A grant ends when its owner lets go or after the final beat of the burst;
  // a stall on full alone never releases.
  assign rel0 = own0 && (!bus.req0 || (beat0 && at_limit));
  assign rel1 = own1 && (!bus.req1 || (beat1 && at_limit));

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (bus.req0) begin
          state_d = OWN0;
        end else if (bus.req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (rel0) begin
          last_d  = 1'b0;
          burst_d = '0;
          if (bus.req1)      state_d = OWN1;
          else if (bus.req0) state_d = OWN0;
          else               state_d = IDLE;
        end else if (beat0) begin
          burst_d = burst_q + CW'(1);
        end
      end
      OWN1: begin
        if (rel1) begin
          last_d  = 1'b1;
          burst_d = '0;
          if (bus.req0)      state_d = OWN0;
          else if (bus.req1) state_d = OWN1;
          else               state_d = IDLE;
        end else if (beat1) begin
          burst_d = burst_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end

  // Write strobe and data follow the beat combinationally so the producer sees
  // its ack in the same cycle the word enters the FIFO.
  always_comb begin
    bus.gnt0         = own0;
    bus.gnt1         = own1;
    bus.ack0         = beat0;
    bus.ack1         = beat1;
    bus.fifo_wr_en   = beat0 || beat1;
    bus.fifo_data_in = '0;
    if (beat0)      bus.fifo_data_in = bus.din0;
    else if (beat1) bus.fifo_data_in = bus.din1;
    bus.burst_cnt    = burst_q;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 8-bit synchronous FIFO between two producers.
- Grants one owner at a time, for a burst of up to MAX_BURST beats.
- Stalls the owner on fifo full and never issues a write while full.
- Sits directly in front of the FIFO's wr_en and data_in and observes its full flag.

Parameters:
- DW, 8, data width; matches FIFO data_in.
- MAX_BURST, 4, maximum beats per grant; legal range 1..255.
- CW, 8, width of the burst counter; must satisfy 2**CW > MAX_BURST.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous assert, active-low; 0 = reset
- req0  in  1  requester 0 has data; held high while din0 is valid
- din0  in  DW  requester 0 data
- req1  in  1  requester 1 has data
- din1  in  DW  requester 1 data
- gnt0  out  1  requester 0 owns the write port
- gnt1  out  1  requester 1 owns the write port
- ack0  out  1  requester 0 beat written this cycle; requester advances din0
- ack1  out  1  requester 1 beat written this cycle
- fifo_full  in  1  FIFO full flag
- fifo_wr_en  out  1  FIFO write enable
- fifo_data_in  out  DW  FIFO write data
- burst_cnt  out  CW  beats accepted in the current grant

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, burst_cnt=0, last=1 (requester 0 wins first).
  - gnt0=gnt1=0, ack0=ack1=0, fifo_wr_en=0, fifo_data_in=0.
- States: IDLE, OWN0, OWN1.
  - gnt0 = (state==OWN0), gnt1 = (state==OWN1); decoded from the state register only.
- Beat for owner i = OWNi && req_i && !fifo_full.
  - On a beat: fifo_wr_en=1, ack_i=1, fifo_data_in=din_i, all in the same cycle.
  - Otherwise fifo_wr_en=0 and fifo_data_in=0.
  - fifo_wr_en=1 while fifo_full=1 is forbidden.
- IDLE:
  - No request: stay in IDLE.
  - Both requesting: go to OWN of the requester that is not last.
  - One requesting: go to OWN of that requester.
  - Grant is visible the next cycle, so arbitration latency is 1 cycle and there is no write in IDLE.
- OWNi:
  - req_i=0: release.
  - Beat with burst_cnt==MAX_BURST-1: release after that beat is written.
  - fifo_full=1 and req_i=1: hold the state; burst_cnt holds. Full never ends a burst.
- Release from OWNi: set last=i and clear burst_cnt.
  - Next state is OWN of the other requester if it is requesting.
  - Else OWNi (new burst) if req_i=1.
  - Else IDLE.
  - Back-to-back handover has no idle cycle.
- burst_cnt increments by 1 on each beat and is cleared on release. It never exceeds MAX_BURST-1 after an update.
- Requests are level-sensitive. A requester dropping req mid-burst forfeits the rest of its burst.
- Reset mid-burst aborts immediately; no partial state is retained.
- Fairness: with both requesting continuously, grants alternate every MAX_BURST beats. Neither requester waits more than MAX_BURST beats plus 1 cycle after the other's burst.

Test Plan:
- Reset with req0=req1=1 → all outputs 0 in reset. The first cycle after release is IDLE; the next cycle gnt0=1; the first beat writes din0.
- req0 only, continuous, din0 sequence 0x11..0x16, MAX_BURST=4, fifo never full:
  - 4 beats are written, then a 1-cycle release with re-grant to OWN0 and no IDLE cycle.
  - fifo_data_in order is 0x11..0x16; burst_cnt goes 0,1,2,3,0.
- req0=req1=1 continuous:
  - Writes follow the pattern 4×din0 then 4×din1, repeating.
  - Handover costs 0 idle cycles; ack pulses match fifo_wr_en exactly.
- fifo_full=1 for 3 cycles in the middle of an OWN1 burst:
  - fifo_wr_en=0 and ack1=0 during those cycles; gnt1 stays 1; burst_cnt holds at 2.
  - The burst resumes and ends after 2 more beats.
- req1 drops after 1 beat while req0 is waiting → the next cycle is OWN0 with burst_cnt=0.
- rst asserted mid-burst (burst_cnt=2) → outputs go to 0 asynchronously. After release, arbitration restarts from IDLE with requester 0 preferred.
